alu_sched: RTL and testbench
============================

ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of per-requester saturating completion counters.
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  [1:0]  request valid, one bit per requester.
REQ-005 SHALL have port: req_ready  output  [1:0]  request accepted this cycle, one bit per requester.
REQ-006 SHALL have port: req_x, req_y  input  [1:0][31:0]  ALU operands per requester.
REQ-007 SHALL have port: req_op  input  [1:0][2:0]  ALU op code per requester.
REQ-008 SHALL have port: rsp_valid  output  1  response valid.
REQ-009 SHALL have port: rsp_ready  input  1  consumer accepts response.
REQ-010 SHALL have port: rsp_id  output  1  requester index the response belongs to.
REQ-011 SHALL have port: rsp_z  output  32  ALU result.
REQ-012 SHALL have port: rsp_zero, rsp_equal, rsp_overflow  output  1 each  ALU flags.
REQ-013 SHALL have port: rsp_err  output  1  request carried reserved op 3'b111.
REQ-014 SHALL have port: busy  output  1  FSM not in IDLE.
REQ-015 SHALL have port: done_cnt  output  [1:0][CNT_W-1:0]  responses delivered per requester.

Function
REQ-016 SHALL share one ALU between two requesters via FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-017 SHALL, in IDLE, assert req_ready only for the granted requester and only while its req_valid is high; req_ready SHALL be 0 in EXEC and RESP.
REQ-018 SHALL, on accept (valid&ready at edge), latch x, y, op, id into operand registers and enter EXEC.
REQ-019 SHALL, in EXEC, drive the ALU from operand registers only and capture z/zero/equal/overflow into result registers at the edge leaving EXEC.
REQ-020 SHALL assert rsp_valid in RESP only; response fields SHALL be registered and stable while rsp_valid=1 and rsp_ready=0.
REQ-021 SHALL return to IDLE on the edge where rsp_valid&rsp_ready; rsp_valid first high the cycle after the second edge following accept (accept edge N -> EXEC -> RESP after edge N+1).
REQ-022 SHALL set rsp_err=1, rsp_z=0 and all flags 0 for op 3'b111; the request still completes normally.
REQ-023 SHALL increment done_cnt[rsp_id] on each response handshake, saturating at all-ones (no wrap).
REQ-024 SHALL ignore req_valid changes and operand changes after accept until the next IDLE.
REQ-025 SHALL keep one transaction in flight maximum; throughput one per 3 cycles with rsp_ready held high.

Reset
REQ-026 SHALL, on n_rst low, immediately force IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_z=0, all flags 0, rsp_err=0, busy=0, done_cnt=0, last-grant register=1.
REQ-027 SHALL discard any in-flight transaction on reset mid-EXEC or mid-RESP; no response is produced for it.

Configuration
REQ-028 SHALL honour macro ALU_SCHED_RR_EN: defined -> round-robin grant (when both valid, grant the requester not granted last; last-grant updates on accept; single valid requester always granted).
REQ-029 SHALL, without ALU_SCHED_RR_EN, use fixed priority: requester 0 wins whenever req_valid[0]=1; last-grant register absent.

Structure
REQ-030 SHALL place op-code enum (AND=000, ADD=001, SUB=010, SLT=011, SRL=100, SRA=101, SLL=110, RSVD=111), FSM state enum and response struct typedef in package alu_sched_pkg.
REQ-031 SHALL instantiate exactly one existing alu module as the shared datapath; grant logic stays inline, no other sub-module.

Verification
REQ-032 SHALL pass: req0 ADD x=5 y=7 -> rsp_valid 2 cycles after accept, rsp_z=12, rsp_id=0, flags 0, done_cnt[0]=1.
REQ-033 SHALL pass: req0 SUB x=0x80000000 y=1 -> rsp_z=0x7FFFFFFF, rsp_overflow=1.
REQ-034 SHALL pass: both req_valid held high for 4 transactions -> grant order 0,1,0,1 with ALU_SCHED_RR_EN; 0,0,0,0 without.
REQ-035 SHALL pass: rsp_ready low 5 cycles in RESP -> rsp fields stable, req_ready=00, busy=1; accepted on cycle rsp_ready rises.
REQ-036 SHALL pass: req1 op=3'b111 x=y=3 -> rsp_err=1, rsp_z=0, rsp_equal=0, rsp_id=1.
REQ-037 SHALL pass: n_rst pulsed low during EXEC -> all outputs 0 immediately, no response after release; CNT_W=2 with 5 req0 completions -> done_cnt[0]=3.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types for the two-requester ALU scheduler: op codes, FSM states and
// the registered response bundle. Used by alu_sched and alu_sched_alu.
package alu_sched_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned N_REQ  = 2;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_SLT  = 3'b011,
    OP_SRL  = 3'b100,
    OP_SRA  = 3'b101,
    OP_SLL  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              id;
    logic [DATA_W-1:0] z;
    logic              zero;
    logic              equal;
    logic              overflow;
    logic              err;
  } rsp_t;

endpackage

// File: rtl/alu_sched_alu.sv
// Purely combinational 32-bit ALU shared by both requesters. The reserved
// op code yields a zero result with every flag cleared and err raised.
module alu_sched_alu
  import alu_sched_pkg::*;
(
  input  op_e               op_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  output logic [DATA_W-1:0] z_o,
  output logic              zero_o,
  output logic              equal_o,
  output logic              overflow_o,
  output logic              err_o
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [4:0]        shamt;

  assign sum   = x_i + y_i;
  assign diff  = x_i - y_i;
  assign shamt = y_i[4:0];

  // Result select, signed-overflow detection and flag generation
  always_comb begin
    z_o        = '0;
    overflow_o = 1'b0;
    err_o      = 1'b0;
    case (op_i)
      OP_AND: z_o = x_i & y_i;
      OP_ADD: begin
        z_o        = sum;
        overflow_o = (x_i[31] == y_i[31]) && (sum[31] != x_i[31]);
      end
      OP_SUB: begin
        z_o        = diff;
        overflow_o = (x_i[31] != y_i[31]) && (diff[31] != x_i[31]);
      end
      OP_SLT: z_o = {31'd0, ($signed(x_i) < $signed(y_i))};
      OP_SRL: z_o = x_i >> shamt;
      OP_SRA: z_o = $unsigned($signed(x_i) >>> shamt);
      OP_SLL: z_o = x_i << shamt;
      default: err_o = 1'b1;
    endcase
    zero_o  = !err_o && (z_o == '0);
    equal_o = !err_o && (x_i == y_i);
  end

endmodule

// File: rtl/alu_sched.sv
// Two-requester scheduler around one shared ALU: IDLE -> EXEC -> RESP.
// Grant is fixed priority (requester 0 first) unless ALU_SCHED_RR_EN is
// defined, which enables round-robin arbitration with a last-grant register.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][31:0]      req_x,
  input  logic [1:0][31:0]      req_y,
  input  logic [1:0][2:0]       req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [31:0]           rsp_z,
  output logic                  rsp_zero,
  output logic                  rsp_equal,
  output logic                  rsp_overflow,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [1:0][CNT_W-1:0] done_cnt
);

  state_e                  state_q, state_d;
  logic                    grant;
  logic                    accept;
  logic                    rsp_fire;
  logic [31:0]             opx_q, opy_q;
  logic [2:0]              opc_q;
  logic                    opid_q;
  rsp_t                    rsp_q;
  rsp_t                    alu_res;
  logic [1:0][CNT_W-1:0]   cnt_q, cnt_d;

`ifdef ALU_SCHED_RR_EN
  logic last_q;

  // Round-robin: on contention favour whoever was not served last
  always_comb begin
    if (req_valid == 2'b11) grant = ~last_q;
    else                    grant = ~req_valid[0];
  end

  // Remember the winner of each accepted request
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      last_q <= 1'b1;
    else if (accept) last_q <= grant;
  end
`else
  // Fixed priority: requester 0 wins whenever it is asking
  always_comb begin
    grant = ~req_valid[0];
  end
`endif

  // Ready only toward the granted, valid requester while idle and out of reset
  always_comb begin
    req_ready = 2'b00;
    if (state_q == ST_IDLE && n_rst) req_ready[grant] = req_valid[grant];
  end

  assign accept    = |(req_valid & req_ready);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign busy      = (state_q != ST_IDLE);

  // FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: one transaction in flight, EXEC always lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_EXEC;
      ST_EXEC:                state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Operand capture on accept; later input changes are ignored
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      opx_q  <= '0;
      opy_q  <= '0;
      opc_q  <= '0;
      opid_q <= 1'b0;
    end else if (accept) begin
      opx_q  <= req_x[grant];
      opy_q  <= req_y[grant];
      opc_q  <= req_op[grant];
      opid_q <= grant;
    end
  end

  alu_sched_alu u_alu (
    .op_i       (op_e'(opc_q)),
    .x_i        (opx_q),
    .y_i        (opy_q),
    .z_o        (alu_res.z),
    .zero_o     (alu_res.zero),
    .equal_o    (alu_res.equal),
    .overflow_o (alu_res.overflow),
    .err_o      (alu_res.err)
  );
  assign alu_res.id = opid_q;

  // Result register loaded on the edge leaving EXEC, held through RESP
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                  rsp_q <= '0;
    else if (state_q == ST_EXEC) rsp_q <= alu_res;
  end

  assign rsp_id       = rsp_q.id;
  assign rsp_z        = rsp_q.z;
  assign rsp_zero     = rsp_q.zero;
  assign rsp_equal    = rsp_q.equal;
  assign rsp_overflow = rsp_q.overflow;
  assign rsp_err      = rsp_q.err;

  // Saturating per-requester completion counters
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (rsp_fire && (rsp_q.id == 1'(i)) && (cnt_q[i] != {CNT_W{1'b1}}))
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  // Counter state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_cnt = cnt_q;

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched (small counters so saturation is reachable).
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  n_rst;
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][31:0]      req_x, req_y;
  logic [1:0][2:0]       req_op;
  logic                  rsp_valid, rsp_ready, rsp_id;
  logic [31:0]           rsp_z;
  logic                  rsp_zero, rsp_equal, rsp_overflow, rsp_err, busy;
  logic [1:0][CNT_W-1:0] done_cnt;

  always #5 clk = ~clk;

  alu_sched #(.CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .rsp_zero(rsp_zero), .rsp_equal(rsp_equal), .rsp_overflow(rsp_overflow),
    .rsp_err(rsp_err), .busy(busy), .done_cnt(done_cnt)
  );

  typedef struct {
    logic        id;
    logic [31:0] z;
    logic        zero, equal, ovf, err;
  } exp_t;

  exp_t sb[$];
  logic acc_log[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   phase   = 0;     // 0 idle, 1 exec, 2 resp (bench model)
  logic last_m  = 1'b1;
  int   cnt_m[2] = '{0, 0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference ALU using 64-bit signed arithmetic for overflow
  function automatic exp_t ref_alu(input logic id, input logic [2:0] op,
                                   input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint sx, sy, s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.id = id; e.z = 32'd0; e.ovf = 1'b0; e.err = 1'b0;
    case (op)
      3'b000: e.z = x & y;
      3'b001: begin s = sx + sy; e.z = s[31:0]; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'b010: begin s = sx - sy; e.z = s[31:0]; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'b011: e.z = (sx < sy) ? 32'd1 : 32'd0;
      3'b100: e.z = x >> y[4:0];
      3'b101: begin s = sx >>> y[4:0]; e.z = s[31:0]; end
      3'b110: e.z = x << y[4:0];
      default: e.err = 1'b1;
    endcase
    e.zero  = !e.err && (e.z == 32'd0);
    e.equal = !e.err && (x == y);
    return e;
  endfunction

  function automatic logic exp_grant(input logic [1:0] v);
`ifdef ALU_SCHED_RR_EN
    if (v == 2'b11) return ~last_m;
`endif
    return v[0] ? 1'b0 : 1'b1;
  endfunction

  // Monitor: per-cycle handshake/state checks, scoreboard push on accept, pop on response
  always @(negedge clk) begin : mon
    logic [1:0] er;
    logic       g;
    exp_t       e;
    er = 2'b00;
    g  = 1'b0;
    if (!n_rst) begin
      phase = 0; sb.delete(); last_m = 1'b1; cnt_m[0] = 0; cnt_m[1] = 0;
    end else begin
      if (phase == 0) begin
        g = exp_grant(req_valid);
        er[g] = req_valid[g];
      end
      chk("req_ready", req_ready, er);
      chk("busy", busy, phase != 0);
      chk("rsp_valid", rsp_valid, phase == 2);
      chk("done_cnt0", done_cnt[0], cnt_m[0]);
      chk("done_cnt1", done_cnt[1], cnt_m[1]);
      case (phase)
        0: if (|(req_valid & er)) begin
             sb.push_back(ref_alu(g, req_op[g], req_x[g], req_y[g]));
             acc_log.push_back(g);
             last_m = g;
             phase  = 1;
           end
        1: phase = 2;
        default: begin
          if (sb.size() == 0) chk("sb_nonempty", 0, 1);
          else begin
            e = sb[0];
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_z", rsp_z, e.z);
            chk("rsp_zero", rsp_zero, e.zero);
            chk("rsp_equal", rsp_equal, e.equal);
            chk("rsp_ovf", rsp_overflow, e.ovf);
            chk("rsp_err", rsp_err, e.err);
            if (rsp_ready) begin
              void'(sb.pop_front());
              if (cnt_m[e.id] < CNT_MAX) cnt_m[e.id]++;
              phase = 0;
              $display("[TB] rsp id=%0d z=0x%08h z/e/o/err=%0b%0b%0b%0b", e.id, rsp_z,
                       rsp_zero, rsp_equal, rsp_overflow, rsp_err);
            end
          end
        end
      endcase
    end
  end

  task automatic wait_accept(input int r);
    bit ok;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = req_valid[r] && req_ready[r];
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    req_x[r] = $urandom; req_y[r] = $urandom; req_op[r] = 3'($urandom);
  endtask

  task automatic issue(input int r, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    req_x[r] = x; req_y[r] = y; req_op[r] = op; req_valid[r] = 1'b1;
    wait_accept(r);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(posedge clk); #1;
      ok = (phase == 0) && (sb.size() == 0) && !busy;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rdy"}, req_ready, 2'b00);
    chk({tag, "_vld"}, rsp_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_id"}, rsp_id, 0);
    chk({tag, "_z"}, rsp_z, 0);
    chk({tag, "_flags"}, {rsp_zero, rsp_equal, rsp_overflow, rsp_err}, 0);
    chk({tag, "_cnt"}, done_cnt, 0);
  endtask

  logic [2:0]  t_op[10] = '{3'b000, 3'b011, 3'b011, 3'b100, 3'b101, 3'b110, 3'b001, 3'b000, 3'b010, 3'b001};
  logic [31:0] t_x[10]  = '{32'hFFFF0F0F, 32'hFFFFFFFD, 32'd5, 32'h80000000, 32'h80000000,
                            32'd1, 32'h7FFFFFFF, 32'h000000F0, 32'd9, 32'hFFFFFFFF};
  logic [31:0] t_y[10]  = '{32'h0FF00FF0, 32'd2, 32'hFFFFFFFF, 32'd4, 32'd4,
                            32'd31, 32'd1, 32'h0000000F, 32'd9, 32'd1};

  initial begin
    n_rst = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    req_x = '0; req_y = '0; req_op = '0;
    #2;
    chk_zero_outputs("reset");
    repeat (3) @(posedge clk);
    #1; req_valid = 2'b00; n_rst = 1'b1;

    // Contention: four back-to-back transactions from both requesters
    acc_log.delete();
    req_x = {32'd20, 32'd10}; req_y = {32'd2, 32'd1}; req_op = {3'b001, 3'b001};
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      bit ok;
      ok = 0;
      for (int t = 0; t < 20 && !ok; t++) begin
        @(negedge clk);
        ok = |(req_valid & req_ready);
      end
      if (!ok) chk("rr_timeout", 0, 1);
      @(posedge clk); #1;
      req_x[0] = $urandom; req_x[1] = $urandom; req_y[0] = $urandom; req_y[1] = $urandom;
    end
    req_valid = 2'b00;
    wait_idle();
    chk("grant_count", acc_log.size(), 4);
    for (int n = 0; n < 4 && n < acc_log.size(); n++) begin
`ifdef ALU_SCHED_RR_EN
      chk($sformatf("grant_%0d", n), acc_log[n], n % 2);
`else
      chk($sformatf("grant_%0d", n), acc_log[n], 0);
`endif
    end

    // Reset during EXEC discards the transaction
    issue(0, 3'b001, 32'd1, 32'd2);
    chk("exec_busy", busy, 1);
    req_valid = 2'b01;
    n_rst = 1'b0;
    #1;
    chk_zero_outputs("rst_exec");
    @(posedge clk); #1;
    req_valid = 2'b00; n_rst = 1'b1;
    repeat (4) @(posedge clk);
    #1; chk("no_rsp_after_rst", rsp_valid, 0);

    // ADD 5+7 with latency check
    issue(0, 3'b001, 32'd5, 32'd7);
    chk("lat_exec", rsp_valid, 0);
    @(posedge clk); #1;
    chk("lat_resp", rsp_valid, 1);
    wait_idle();
    chk("add_cnt0", done_cnt[0], 1);

    // SUB signed overflow
    issue(0, 3'b010, 32'h80000000, 32'd1);
    wait_idle();

    // Mixed ops alternating between requesters
    for (int i = 0; i < 10; i++) begin
      issue(i % 2, t_op[i], t_x[i], t_y[i]);
      wait_idle();
    end

    // Reserved op from requester 1
    issue(1, 3'b111, 32'd3, 32'd3);
    wait_idle();

    // Back-pressure: response held five cycles while requester 1 waits
    rsp_ready = 1'b0;
    issue(0, 3'b000, 32'hDEADBEEF, 32'hFFFF0000);
    req_x[1] = 32'd100; req_y[1] = 32'd58; req_op[1] = 3'b010; req_valid[1] = 1'b1;
    begin
      bit ok;
      ok = 0;
      for (int t = 0; t < 10 && !ok; t++) begin
        @(posedge clk); #1;
        ok = rsp_valid;
      end
      if (!ok) chk("stall_rsp_timeout", 0, 1);
    end
    repeat (5) @(posedge clk);
    #1; chk("stall_busy", busy, 1);
    rsp_ready = 1'b1;
    wait_accept(1);
    wait_idle();

    // Counter saturation with five requester-0 completions after reset
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(0, 3'b001, 32'(i), 32'd1);
      wait_idle();
    end
    chk("sat_cnt0", done_cnt[0], CNT_MAX);
    chk("sat_cnt1", done_cnt[1], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
